// File: rtl/gfx_timing_pkg.sv
//------------------------------------------------------------------------------
// gfx_timing_pkg
// Shared raster geometry for the graphics pipeline: default dot prescale,
// horizontal/vertical visible and total sizes, counter widths, the packed
// raster flag bundle registered by the scan timer, and a small width helper.
// No ports (package).
//------------------------------------------------------------------------------
package gfx_timing_pkg;

   localparam int GFX_CYC_PER_DOT = 4;
   localparam int GFX_H_VIS       = 240;
   localparam int GFX_H_TOT       = 308;
   localparam int GFX_V_VIS       = 160;
   localparam int GFX_V_TOT       = 228;
   localparam int GFX_HCNT_W      = 9;
   localparam int GFX_VCNT_W      = 8;

   // Raster-position flags that are registered together with the counters.
   typedef struct packed {
      logic hblank;
      logic vblank;
      logic line_start;
      logic frame_start;
   } gfx_raster_t;

   // Prescaler counter width: enough bits for 0..cyc-1, never less than 1.
   function automatic int gfx_psc_width(input int cyc);
      return (cyc <= 2) ? 1 : $clog2(cyc);
   endfunction

endpackage

// File: rtl/gfx_dot_prescaler.sv
//------------------------------------------------------------------------------
// gfx_dot_prescaler
// Divides the system clock into dot slots of CYCLES_PER_DOT clocks.
// Ports:
//   clock    in  system clock
//   rst_b    in  asynchronous active-low reset
//   run      in  1 = count, 0 = hold the current slot position
//   restart  in  synchronous return to slot position 0 (beats run)
//   dot_en   out 1-clock strobe on the last clock of each dot slot
//------------------------------------------------------------------------------
module gfx_dot_prescaler
   import gfx_timing_pkg::*;
#(
   parameter int CYCLES_PER_DOT = GFX_CYC_PER_DOT
)(
   input  logic clock,
   input  logic rst_b,
   input  logic run,
   input  logic restart,
   output logic dot_en
);

   localparam int               PSC_W    = gfx_psc_width(CYCLES_PER_DOT);
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(CYCLES_PER_DOT - 1);

   logic [PSC_W-1:0] psc;

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clock or negedge rst_b) begin
      if (!rst_b) begin
         psc <= '0;
      end else if (restart) begin
         psc <= '0;
      end else if (run) begin
         psc <= (psc == PSC_LAST) ? '0 : psc + PSC_W'(1);
      end
   end

   // Combinational from the registered slot position; gated by run so a
   // frozen raster never produces a strobe.
   assign dot_en = run && (psc == PSC_LAST);

endmodule

// File: rtl/gfx_scan_timer.sv
//------------------------------------------------------------------------------
// gfx_scan_timer
// Master raster sequencer: dot prescaler, hcount/vcount, blank flags,
// line/frame strobes and HBlank/VBlank/VCount-match interrupt pulses.
// All flags and pulses are registered from the same next-state values as the
// counters, so they always describe the hcount/vcount visible that cycle.
//
// Build option: define GFX_VCOUNT_IRQ_EN to include the lyc compare logic;
// without it lyc is ignored and vcount_match/irq_vcount are constant 0.
//
// Ports:
//   clock         in   system clock
//   rst_b         in   asynchronous active-low reset
//   run           in   1 = advance raster, 0 = freeze everything
//   restart       in   synchronous return to (0,0) with prescaler 0
//   lyc           in   [7:0] vcount compare value
//   dot_en        out  strobe on the last clock of each dot slot
//   hcount        out  [8:0] current dot, 0..H_TOTAL-1
//   vcount        out  [7:0] current line, 0..V_TOTAL-1
//   hblank        out  hcount >= H_VISIBLE
//   vblank        out  V_VISIBLE <= vcount <= V_TOTAL-2
//   line_start    out  pulse when hcount becomes 0
//   frame_start   out  pulse when (hcount,vcount) becomes (0,0)
//   vcount_match  out  level, vcount == lyc
//   irq_hblank    out  pulse when hcount becomes H_VISIBLE
//   irq_vblank    out  pulse when vcount becomes V_VISIBLE
//   irq_vcount    out  pulse when vcount becomes lyc
//------------------------------------------------------------------------------
module gfx_scan_timer
   import gfx_timing_pkg::*;
#(
   parameter int CYCLES_PER_DOT = GFX_CYC_PER_DOT,
   parameter int H_VISIBLE      = GFX_H_VIS,
   parameter int H_TOTAL        = GFX_H_TOT,
   parameter int V_VISIBLE      = GFX_V_VIS,
   parameter int V_TOTAL        = GFX_V_TOT
)(
   input  logic                  clock,
   input  logic                  rst_b,
   input  logic                  run,
   input  logic                  restart,
   input  logic [GFX_VCNT_W-1:0] lyc,
   output logic                  dot_en,
   output logic [GFX_HCNT_W-1:0] hcount,
   output logic [GFX_VCNT_W-1:0] vcount,
   output logic                  hblank,
   output logic                  vblank,
   output logic                  line_start,
   output logic                  frame_start,
   output logic                  vcount_match,
   output logic                  irq_hblank,
   output logic                  irq_vblank,
   output logic                  irq_vcount
);

   localparam logic [GFX_HCNT_W-1:0] H_LAST      = GFX_HCNT_W'(H_TOTAL - 1);
   localparam logic [GFX_HCNT_W-1:0] H_VIS_FIRST = GFX_HCNT_W'(H_VISIBLE);
   localparam logic [GFX_HCNT_W-1:0] H_VIS_LAST  = GFX_HCNT_W'(H_VISIBLE - 1);
   localparam logic [GFX_VCNT_W-1:0] V_LAST      = GFX_VCNT_W'(V_TOTAL - 1);
   localparam logic [GFX_VCNT_W-1:0] V_VIS_FIRST = GFX_VCNT_W'(V_VISIBLE);
   localparam logic [GFX_VCNT_W-1:0] V_VIS_LAST  = GFX_VCNT_W'(V_VISIBLE - 1);
   // The final line of the frame is outside vblank.
   localparam logic [GFX_VCNT_W-1:0] V_BLK_LAST  = GFX_VCNT_W'(V_TOTAL - 2);

   //---------------------------------------------------------------------------
   // Dot prescaler
   //---------------------------------------------------------------------------
   gfx_dot_prescaler #(
      .CYCLES_PER_DOT (CYCLES_PER_DOT)
   ) u_prescaler (
      .clock   (clock),
      .rst_b   (rst_b),
      .run     (run),
      .restart (restart),
      .dot_en  (dot_en)
   );

   //---------------------------------------------------------------------------
   // Next raster position and the flags that describe it
   //---------------------------------------------------------------------------
   logic                  h_wrap;
   logic                  v_wrap;
   logic [GFX_HCNT_W-1:0] hcount_nxt;
   logic [GFX_VCNT_W-1:0] vcount_nxt;
   gfx_raster_t           raster_nxt;
   gfx_raster_t           raster;
   logic                  irq_hblank_nxt;
   logic                  irq_vblank_nxt;

   assign h_wrap = dot_en && (hcount == H_LAST);
   assign v_wrap = h_wrap && (vcount == V_LAST);

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      hcount_nxt = hcount;
      vcount_nxt = vcount;
      if (restart) begin
         // Beats run and any coincident wrap; the wrap cannot add a second
         // frame_start because restart already lands on (0,0).
         hcount_nxt = '0;
         vcount_nxt = '0;
      end else if (dot_en) begin
         if (h_wrap) begin
            hcount_nxt = '0;
            vcount_nxt = v_wrap ? '0 : vcount + GFX_VCNT_W'(1);
         end else begin
            hcount_nxt = hcount + GFX_HCNT_W'(1);
         end
      end

      raster_nxt.hblank      = (hcount_nxt >= H_VIS_FIRST);
      raster_nxt.vblank      = (vcount_nxt >= V_VIS_FIRST) && (vcount_nxt <= V_BLK_LAST);
      raster_nxt.line_start  = restart || h_wrap;
      raster_nxt.frame_start = restart || v_wrap;

      // Interrupts fire only on a real advance into the boundary; restart
      // always lands on (0,0), which is neither boundary.
      irq_hblank_nxt = !restart && dot_en && (hcount == H_VIS_LAST);
      irq_vblank_nxt = !restart && h_wrap && (vcount == V_VIS_LAST);
   end

   //---------------------------------------------------------------------------
   // Counter and flag registers. With run=0 and no restart the next-state
   // equals the current state, so levels hold and all pulses drop to 0.
   //---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge rst_b) begin
      if (!rst_b) begin
         hcount     <= '0;
         vcount     <= '0;
         raster     <= '0;
         irq_hblank <= 1'b0;
         irq_vblank <= 1'b0;
      end else begin
         hcount     <= hcount_nxt;
         vcount     <= vcount_nxt;
         raster     <= raster_nxt;
         irq_hblank <= irq_hblank_nxt;
         irq_vblank <= irq_vblank_nxt;
      end
   end

   assign hblank      = raster.hblank;
   assign vblank      = raster.vblank;
   assign line_start  = raster.line_start;
   assign frame_start = raster.frame_start;

   //---------------------------------------------------------------------------
   // VCount compare
   //---------------------------------------------------------------------------
`ifdef GFX_VCOUNT_IRQ_EN
   localparam logic [GFX_VCNT_W:0] V_TOT_EXT = (GFX_VCNT_W + 1)'(V_TOTAL);

   logic lyc_valid;
   logic line_change;

   // An lyc beyond the last line can never be a vcount value; the explicit
   // guard keeps that true even if the geometry is changed.
   assign lyc_valid   = ({1'b0, lyc} < V_TOT_EXT);
   // vcount only moves at a line wrap or a restart.
   assign line_change = restart || h_wrap;

   always_ff @(posedge clock or negedge rst_b) begin
      if (!rst_b) begin
         vcount_match <= 1'b0;
         irq_vcount   <= 1'b0;
      end else begin
         // The level follows lyc every clock; the pulse needs a line change.
         vcount_match <= lyc_valid && (vcount_nxt == lyc);
         irq_vcount   <= lyc_valid && line_change && (vcount_nxt == lyc);
      end
   end
`else
   logic lyc_unused;

   assign lyc_unused   = ^lyc;
   assign vcount_match = 1'b0;
   assign irq_vcount   = 1'b0;
`endif

endmodule

// File: tb/tb_gfx_scan_timer.sv
//------------------------------------------------------------------------------
// tb_gfx_scan_timer
// Self-checking bench for gfx_scan_timer. The reference model keeps a single
// count of run clocks since the last restart and derives the slot, dot, line,
// flags and pulses from it arithmetically. Horizontal geometry is shrunk so
// whole frames fit in a short run; the vertical geometry is the real one so
// the 8-bit lyc compare range is exercised as built.
//------------------------------------------------------------------------------
module tb_gfx_scan_timer;

   localparam int CPD       = 4;
   localparam int HV        = 12;
   localparam int HT        = 16;
   localparam int VV        = 160;
   localparam int VT        = 228;
   localparam int LINE_CLK  = CPD * HT;
   localparam int FRAME_CLK = LINE_CLK * VT;
`ifdef GFX_VCOUNT_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic       clock   = 1'b0;
   logic       rst_b   = 1'b0;
   logic       run     = 1'b0;
   logic       restart = 1'b0;
   logic [7:0] lyc     = 8'd0;

   logic       dot_en;
   logic [8:0] hcount;
   logic [7:0] vcount;
   logic       hblank, vblank, line_start, frame_start;
   logic       vcount_match, irq_hblank, irq_vblank, irq_vcount;

   gfx_scan_timer #(
      .CYCLES_PER_DOT (CPD),
      .H_VISIBLE      (HV),
      .H_TOTAL        (HT),
      .V_VISIBLE      (VV),
      .V_TOTAL        (VT)
   ) dut (
      .clock        (clock),
      .rst_b        (rst_b),
      .run          (run),
      .restart      (restart),
      .lyc          (lyc),
      .dot_en       (dot_en),
      .hcount       (hcount),
      .vcount       (vcount),
      .hblank       (hblank),
      .vblank       (vblank),
      .line_start   (line_start),
      .frame_start  (frame_start),
      .vcount_match (vcount_match),
      .irq_hblank   (irq_hblank),
      .irq_vblank   (irq_vblank),
      .irq_vcount   (irq_vcount)
   );

   always #5 clock = ~clock;

   // Observed bundle: {dot_en, hcount, vcount, hblank, vblank, line_start,
   // frame_start, vcount_match, irq_hblank, irq_vblank, irq_vcount}
   logic [25:0] obs;
   assign obs = {dot_en, hcount, vcount, hblank, vblank, line_start,
                 frame_start, vcount_match, irq_hblank, irq_vblank, irq_vcount};

   int          checks = 0;
   int          errors = 0;
   longint      n      = 0;     // run clocks since last restart/reset
   logic [25:0] exp_vec = '0;

   //---------------------------------------------------------------------------
   // Reference model
   //---------------------------------------------------------------------------
   function automatic int cur_h();
      return int'((n / CPD) % HT);
   endfunction

   function automatic int cur_v();
      return int'((n / CPD / HT) % VT);
   endfunction

   // Applies one clock edge to the model using the inputs held at that edge.
   task automatic model_edge();
      bit ls, fs, ih, iv, ivc, de, hb, vb, vm;
      int h, v;
      ls = 0; fs = 0; ih = 0; iv = 0; ivc = 0;
      if (!rst_b) begin
         n = 0;
         exp_vec = '0;
         return;
      end
      if (restart) begin
         n   = 0;
         ls  = 1;
         fs  = 1;
         ivc = IRQ_EN && (lyc == 8'd0);
      end else if (run) begin
         n++;
         if (n % CPD == 0) begin
            h   = cur_h();
            v   = cur_v();
            ls  = (h == 0);
            fs  = (h == 0) && (v == 0);
            ih  = (h == HV);
            iv  = (h == 0) && (v == VV);
            ivc = IRQ_EN && (h == 0) && (v == int'(lyc));
         end
      end
      h  = cur_h();
      v  = cur_v();
      hb = (h >= HV);
      vb = (v >= VV) && (v <= VT - 2);
      vm = IRQ_EN && (v == int'(lyc));
      de = run && (n % CPD == CPD - 1);
      exp_vec = {de, 9'(h), 8'(v), hb, vb, ls, fs, vm, ih, iv, ivc};
   endtask

   // One clock: edge, model update, then settle before anyone samples.
   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   //---------------------------------------------------------------------------
   // Scenarios
   //---------------------------------------------------------------------------
   task automatic test_reset();
      #1;
      checks++;
      if (obs !== 26'd0) begin
         errors++;
         $display("FAIL reset_initial: dut=%h want=0", obs);
      end
      #2 rst_b = 1'b1;
      n = 0;
      exp_vec = '0;
   endtask

   task automatic test_dot_rate();
      int first_de = 0;
      int ls_at[$];
      run = 1'b1;
      for (int k = 1; k <= 2 * LINE_CLK + 4; k++) begin
         tick();
         checks++;
         if (obs !== exp_vec) begin
            errors++;
            $display("FAIL dot_rate k=%0d: dut=%h model=%h", k, obs, exp_vec);
         end
         if (dot_en && first_de == 0) first_de = k + 1;
         if (line_start) ls_at.push_back(k);
         if (k == CPD) begin
            checks++;
            if (hcount !== 9'd1) begin
               errors++;
               $display("FAIL first_dot_hcount: dut=%0d want=1", hcount);
            end
         end
      end
      checks++;
      if (first_de != CPD) begin
         errors++;
         $display("FAIL first_dot_en_clock: dut=%0d want=%0d", first_de, CPD);
      end
      checks++;
      if (ls_at.size() < 2) begin
         errors++;
         $display("FAIL line_period: saw %0d line_start pulses, want 2", ls_at.size());
      end else if (ls_at[1] - ls_at[0] != LINE_CLK) begin
         errors++;
         $display("FAIL line_period: dut=%0d want=%0d", ls_at[1] - ls_at[0], LINE_CLK);
      end
   endtask

   task automatic test_reset_mid();
      int cnt = 0;
      while (!(cur_v() == 50 && cur_h() == 10) && cnt < 60 * LINE_CLK) begin
         tick();
         cnt++;
         checks++;
         if (obs !== exp_vec) begin
            errors++;
            $display("FAIL reach_50 cnt=%0d: dut=%h model=%h", cnt, obs, exp_vec);
         end
      end
      checks++;
      if (cnt >= 60 * LINE_CLK) begin
         errors++;
         $display("FAIL reach_50: position (10,50) not reached, dut=%h", obs);
      end
      #2 rst_b = 1'b0;
      #1;
      checks++;
      if (obs !== 26'd0) begin
         errors++;
         $display("FAIL reset_async: dut=%h want=0", obs);
      end
      n = 0;
      exp_vec = '0;
      tick();
      checks++;
      if (obs !== exp_vec) begin
         errors++;
         $display("FAIL reset_hold: dut=%h model=%h", obs, exp_vec);
      end
      rst_b = 1'b1;
   endtask

   task automatic test_frame();
      int frame_at = 0, lines = 0, hb_irq = 0, vb_irq = 0, vc_irq = 0;
      int match_clk = 0, vb_clk = 0;
      lyc     = 8'd100;
      restart = 1'b1;
      tick();
      restart = 1'b0;
      checks++;
      if (obs !== exp_vec || frame_start !== 1'b1) begin
         errors++;
         $display("FAIL frame_restart: dut=%h model=%h", obs, exp_vec);
      end
      for (int i = 1; i <= FRAME_CLK + 2; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec) begin
            errors++;
            $display("FAIL frame i=%0d: dut=%h model=%h", i, obs, exp_vec);
         end
         if (frame_start && frame_at == 0) frame_at = i;
         lines     += int'(line_start);
         hb_irq    += int'(irq_hblank);
         vb_irq    += int'(irq_vblank);
         vc_irq    += int'(irq_vcount);
         match_clk += int'(vcount_match);
         vb_clk    += int'(vblank);
      end
      checks++;
      if (frame_at != FRAME_CLK) begin
         errors++;
         $display("FAIL frame_period: dut=%0d want=%0d", frame_at, FRAME_CLK);
      end
      checks++;
      if (lines != VT || hb_irq != VT) begin
         errors++;
         $display("FAIL line_counts: line_start=%0d irq_hblank=%0d want=%0d", lines, hb_irq, VT);
      end
      checks++;
      if (vb_irq != 1) begin
         errors++;
         $display("FAIL irq_vblank_count: dut=%0d want=1", vb_irq);
      end
      checks++;
      if (vb_clk != (VT - 1 - VV) * LINE_CLK) begin
         errors++;
         $display("FAIL vblank_clocks: dut=%0d want=%0d", vb_clk, (VT - 1 - VV) * LINE_CLK);
      end
      checks++;
      if (vc_irq != (IRQ_EN ? 1 : 0) || match_clk != (IRQ_EN ? LINE_CLK : 0)) begin
         errors++;
         $display("FAIL vcount_compare: irq=%0d match_clk=%0d want %0d/%0d", vc_irq, match_clk,
                  IRQ_EN ? 1 : 0, IRQ_EN ? LINE_CLK : 0);
      end
   endtask

   task automatic test_freeze();
      int cnt = 0, pulses = 0;
      while (!(cur_h() == 10 && n % CPD == 2) && cnt < 2 * LINE_CLK) begin
         tick();
         cnt++;
      end
      checks++;
      if (cnt >= 2 * LINE_CLK || hcount !== 9'd10) begin
         errors++;
         $display("FAIL freeze_reach: hcount=%0d want=10", hcount);
      end
      run = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec) begin
            errors++;
            $display("FAIL freeze i=%0d: dut=%h model=%h", i, obs, exp_vec);
         end
         pulses += int'(line_start) + int'(frame_start) + int'(irq_hblank) +
                   int'(irq_vblank) + int'(irq_vcount) + int'(dot_en);
      end
      checks++;
      if (pulses != 0 || hcount !== 9'd10) begin
         errors++;
         $display("FAIL freeze_hold: pulses=%0d hcount=%0d want 0/10", pulses, hcount);
      end
      run = 1'b1;
      tick();
      checks++;
      if (dot_en !== 1'b1 || hcount !== 9'd10) begin
         errors++;
         $display("FAIL resume_dot_en: dot_en=%b hcount=%0d want 1/10", dot_en, hcount);
      end
      tick();
      checks++;
      if (hcount !== 9'd11 || obs !== exp_vec) begin
         errors++;
         $display("FAIL resume_hcount: dut=%h model=%h", obs, exp_vec);
      end
   endtask

   task automatic test_restart_wrap();
      int fs_cnt;
      restart = 1'b1;
      tick();
      restart = 1'b0;
      for (int i = 1; i < FRAME_CLK; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec) begin
            errors++;
            $display("FAIL to_wrap i=%0d: dut=%h model=%h", i, obs, exp_vec);
         end
      end
      checks++;
      if (dot_en !== 1'b1 || hcount !== 9'(HT - 1) || vcount !== 8'(VT - 1)) begin
         errors++;
         $display("FAIL wrap_position: dot_en=%b h=%0d v=%0d want 1/%0d/%0d",
                  dot_en, hcount, vcount, HT - 1, VT - 1);
      end
      restart = 1'b1;
      tick();
      restart = 1'b0;
      checks++;
      if (obs !== exp_vec || hcount !== 9'd0 || vcount !== 8'd0) begin
         errors++;
         $display("FAIL restart_on_wrap: dut=%h model=%h", obs, exp_vec);
      end
      fs_cnt = int'(frame_start);
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec) begin
            errors++;
            $display("FAIL after_wrap i=%0d: dut=%h model=%h", i, obs, exp_vec);
         end
         fs_cnt += int'(frame_start);
      end
      checks++;
      if (fs_cnt != 1) begin
         errors++;
         $display("FAIL single_frame_start: dut=%0d want=1", fs_cnt);
      end
   endtask

   task automatic test_restart_mid();
      int cnt = 0;
      while (!(cur_v() == 80 && cur_h() == 8) && cnt < 90 * LINE_CLK) begin
         tick();
         cnt++;
         checks++;
         if (obs !== exp_vec) begin
            errors++;
            $display("FAIL reach_80 cnt=%0d: dut=%h model=%h", cnt, obs, exp_vec);
         end
      end
      checks++;
      if (cnt >= 90 * LINE_CLK || vcount !== 8'd80) begin
         errors++;
         $display("FAIL reach_80: vcount=%0d want=80", vcount);
      end
      restart = 1'b1;
      tick();
      restart = 1'b0;
      checks++;
      if (frame_start !== 1'b1 || hcount !== 9'd0 || vcount !== 8'd0 || obs !== exp_vec) begin
         errors++;
         $display("FAIL restart_mid: dut=%h model=%h", obs, exp_vec);
      end
   endtask

   task automatic test_random();
      int hits = 0;
      lyc = 8'd250;
      for (int i = 0; i < 1500; i++) begin
         run     = ($urandom_range(0, 3) != 0);
         restart = ($urandom_range(0, 399) == 0);
         tick();
         checks++;
         if (obs !== exp_vec) begin
            errors++;
            $display("FAIL random_lyc250 i=%0d: dut=%h model=%h", i, obs, exp_vec);
         end
         hits += int'(irq_vcount) + int'(vcount_match);
      end
      checks++;
      if (hits != 0) begin
         errors++;
         $display("FAIL lyc_out_of_range: hits=%0d want=0", hits);
      end
      for (int i = 0; i < 1500; i++) begin
         run     = ($urandom_range(0, 3) != 0);
         restart = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 99) == 0) lyc = 8'(cur_v() + int'($urandom_range(0, 2)));
         tick();
         checks++;
         if (obs !== exp_vec) begin
            errors++;
            $display("FAIL random i=%0d: dut=%h model=%h", i, obs, exp_vec);
         end
      end
      run     = 1'b1;
      restart = 1'b0;
   endtask

   //---------------------------------------------------------------------------
   // Sequence
   //---------------------------------------------------------------------------
   initial begin
      test_reset();
      test_dot_rate();
      test_reset_mid();
      test_frame();
      test_freeze();
      test_restart_wrap();
      test_restart_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
